// File: rtl/goldschmidt_prescaler.sv
// Two-stage operand prescaler for a Goldschmidt divider: normalizes the divisor to Q0.32 in [0.5,1).
// Optional zero-divisor flagging is enabled with `define GS_PRESCALE_DIV0_DETECT_EN.
module goldschmidt_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_norm,
    output logic [5:0]  shift,
    output logic        div0
);

    localparam int DATA_W = 32;

    // Leading-zero count of v; an all-zero word yields DATA_W.
    function automatic logic [5:0] f_lzc(input logic [DATA_W-1:0] v);
        logic [5:0] n;
        n = 6'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) n = 6'(DATA_W - 1 - i);
        end
        return n;
    endfunction

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [5:0]        r_s1_lzc;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_a_out;
    logic [DATA_W-1:0] r_b_norm;
    logic signed [5:0] r_shift;

    logic              w_s2_load;
    logic              w_s1_load;
    logic [DATA_W-1:0] w_b_norm;
    logic signed [5:0] w_shift;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    // A count of 32 means b was zero; the normalized value is then zero too.
    assign w_b_norm = r_s1_lzc[5] ? '0 : (r_s1_b << r_s1_lzc[4:0]);

    // ---- stage 1: capture operands and divisor leading-zero count ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_lzc   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a   <= a;
                r_s1_b   <= b;
                r_s1_lzc <= f_lzc(b);
            end
        end
    end

`ifdef GS_PRESCALE_DIV0_DETECT_EN
    logic r_div0;
    logic w_div0;

    assign w_div0  = (r_s1_b == '0);
    assign w_shift = w_div0 ? 6'sd0 : ($signed(r_s1_lzc) - 6'sd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_div0 <= w_div0;
        end
    end

    assign div0 = r_div0;
`else
    // Modular arithmetic maps lzc=32 to +16 as required for a zero divisor.
    assign w_shift = $signed(r_s1_lzc) - 6'sd16;
    assign div0    = 1'b0;
`endif

    // ---- stage 2: normalized divisor and scale exponent ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_a_out    <= '0;
            r_b_norm   <= '0;
            r_shift    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_a_out  <= r_s1_a;
                r_b_norm <= w_b_norm;
                r_shift  <= w_shift;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign a_out     = r_a_out;
    assign b_norm    = r_b_norm;
    assign shift     = r_shift;

endmodule
